// File: rtl/key_event_queue.sv
// Keypad event queue: debounces scanner press/release and queues one event per press.
// Optional build macro AUTOREPEAT_EN adds auto-repeat pushes while a key stays held.
module key_event_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DB_W            = 5,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned PTR_W           = 2,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_RATE     = 200,
  parameter int unsigned RPT_W           = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       BCDKey,
  input  logic             KeyRead,
  output logic [3:0]       key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [PTR_W:0]   key_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

  localparam logic [DB_W-1:0]  DbLast   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FullCnt  = (PTR_W + 1)'(FIFO_DEPTH);

  state_e            state_q;
  logic [DB_W-1:0]   cnt_q;
  logic [3:0]        cand_q;

  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q;

  logic press_push, rpt_hit, push, pop, full, wr_en, drop;

  // Debounce FSM: one sample per clock, counter shared by press and release phases.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (KeyRead) begin
            cand_q  <= BCDKey;
            cnt_q   <= DB_W'(1);
            state_q <= StPressDb;
          end
        end
        StPressDb: begin
          if (!KeyRead || (BCDKey != cand_q)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (cnt_q == DbLast) begin
            cnt_q   <= '0;
            state_q <= StHeld;
          end else begin
            cnt_q <= cnt_q + DB_W'(1);
          end
        end
        StHeld: begin
          if (!KeyRead) begin
            cnt_q   <= DB_W'(1);
            state_q <= StRelDb;
          end
        end
        StRelDb: begin
          if (KeyRead) begin
            cnt_q   <= '0;
            state_q <= StHeld;
          end else if (cnt_q == DbLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + DB_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign press_push = (state_q == StPressDb) && KeyRead && (BCDKey == cand_q) && (cnt_q == DbLast);

`ifdef AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt_q;
  logic             rpt_rate_q;

  assign rpt_hit = (state_q == StHeld) && KeyRead &&
                   (rpt_q == (rpt_rate_q ? RPT_W'(REPEAT_RATE - 1) : RPT_W'(REPEAT_DELAY - 1)));

  // Any exit from the held phase restarts the long initial delay.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rpt_q      <= '0;
      rpt_rate_q <= 1'b0;
    end else if ((state_q == StHeld) && KeyRead) begin
      if (rpt_hit) begin
        rpt_q      <= '0;
        rpt_rate_q <= 1'b1;
      end else begin
        rpt_q <= rpt_q + RPT_W'(1);
      end
    end else begin
      rpt_q      <= '0;
      rpt_rate_q <= 1'b0;
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_RATE, RPT_W};
  assign rpt_hit = 1'b0;
`endif

  assign push      = press_push || rpt_hit;
  assign key_valid = (count_q != '0);
  assign pop       = key_valid && key_ready;
  assign full      = (count_q == FullCnt);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)   rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wptr_q] <= cand_q;
  end

  assign key_code  = key_valid ? mem_q[rptr_q] : 4'h0;
  assign key_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: per-cycle compare against an event-level model
// plus literal checks of latency, codes, occupancy and overflow.
module tb_key_event_queue;

  localparam int DB     = 16;
  localparam int DEPTH  = 4;
  localparam int RDELAY = 1000;
  localparam int RRATE  = 200;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] BCDKey;
  logic       KeyRead;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] key_count;
  logic       overflow;
  logic       ovf_clr;

  always #5 CLK = ~CLK;

  key_event_queue dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BCDKey    (BCDKey),
    .KeyRead   (KeyRead),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_count (key_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state: queued codes, sticky overflow, press/release run lengths.
  int         q[$];
  bit         m_ovf;
  bit         m_pressed;
  int         m_run;
  int         m_low;
  int         m_held;
  logic [3:0] m_cand;

  int ticks;
  int fv;
  int obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ovf     = 1'b0;
    m_pressed = 1'b0;
    m_run     = 0;
    m_low     = 0;
    m_held    = 0;
    m_cand    = 4'h0;
  endfunction

  task automatic model_step();
    bit push;
    bit pop;
    bit drop;
    push = 1'b0;
    drop = 1'b0;
    if (RESET) begin
      model_reset();
      return;
    end
    pop = key_ready && (q.size() != 0);
    if (!m_pressed) begin
      if (m_run == 0) begin
        if (KeyRead) begin
          m_cand = BCDKey;
          m_run  = 1;
        end
      end else if (KeyRead && BCDKey == m_cand) begin
        m_run++;
        if (m_run == DB) begin
          push      = 1'b1;
          m_pressed = 1'b1;
          m_run     = 0;
          m_low     = 0;
          m_held    = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_low == 0) begin
      if (!KeyRead) begin
        m_low  = 1;
        m_held = 0;
      end else begin
        m_held++;
`ifdef AUTOREPEAT_EN
        if (m_held == RDELAY || (m_held > RDELAY && (m_held - RDELAY) % RRATE == 0)) push = 1'b1;
`endif
      end
    end else begin
      if (KeyRead) m_low = 0;
      else begin
        m_low++;
        if (m_low == DB) begin
          m_pressed = 1'b0;
          m_low     = 0;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(int'(m_cand));
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic compare();
    chk("key_valid", key_valid, q.size() != 0);
    chk("key_count", key_count, q.size());
    chk("overflow", overflow, m_ovf);
    if (q.size() != 0) chk("key_code", key_code, q[0]);
  endtask

  task automatic tick();
    if (key_valid && key_ready) obs.push_back(int'(key_code));
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    ticks++;
    if (key_valid && fv < 0) fv = ticks;
    compare();
  endtask

  task automatic hold(input bit kr, input logic [3:0] code, input int n);
    KeyRead = kr;
    BCDKey  = code;
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] code);
    hold(1'b1, code, 20);
    hold(1'b0, code, 20);
  endtask

  task automatic start_test();
    obs.delete();
    fv    = -1;
    ticks = 0;
  endtask

  function automatic int obs_at(input int i);
    return (i < obs.size()) ? obs[i] : -1;
  endfunction

  initial begin
    int exp4[4];
    int exp_hold;
    exp4 = '{1, 2, 3, 4};
    RESET = 1'b1; BCDKey = 4'h0; KeyRead = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    ticks = 0;
    fv = -1;
    #1;
    chk("rst_valid", key_valid, 0);
    chk("rst_count", key_count, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge CLK);
    tick();
    tick();
    RESET = 1'b0;

    // Clean press
    start_test();
    key_ready = 1'b1;
    hold(1'b1, 4'd5, 40);
    hold(1'b0, 4'd5, 20);
    chk("t1_events", obs.size(), 1);
    chk("t1_code", obs_at(0), 5);
    chk("t1_latency", fv, 16);

    // Bounce: the dropout restarts the debounce
    start_test();
    hold(1'b1, 4'd2, 10);
    hold(1'b0, 4'd2, 1);
    hold(1'b1, 4'd2, 30);
    hold(1'b0, 4'd2, 20);
    chk("t2_events", obs.size(), 1);
    chk("t2_latency", fv, 27);

    // Code change during debounce
    start_test();
    hold(1'b1, 4'd7, 8);
    hold(1'b1, 4'd12, 30);
    hold(1'b0, 4'd12, 20);
    chk("t3_events", obs.size(), 1);
    chk("t3_code", obs_at(0), 12);

    // Overflow with consumer stalled
    start_test();
    key_ready = 1'b0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd6);
    chk("t4_count", key_count, 4);
    chk("t4_ovf", overflow, 1);
    key_ready = 1'b1;
    hold(1'b0, 4'd0, 4);
    key_ready = 1'b0;
    chk("t4_pops", obs.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_pop_code", obs_at(i), exp4[i]);
    chk("t4_ovf_held", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", overflow, 0);

    // Push and pop on the same edge while full
    start_test();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    hold(1'b1, 4'd8, 15);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("t5_count", key_count, 4);
    chk("t5_ovf", overflow, 0);
    chk("t5_head", key_code, 2);
    obs.delete();
    key_ready = 1'b1;
    hold(1'b1, 4'd8, 4);
    key_ready = 1'b0;
    chk("t5_first", obs_at(0), 2);
    chk("t5_last", obs_at(3), 8);
    hold(1'b0, 4'd8, 20);

    // Reset during press debounce
    start_test();
    key_ready = 1'b1;
    hold(1'b1, 4'd3, 8);
    RESET = 1'b1;
    #1;
    chk("t6_rst_valid", key_valid, 0);
    chk("t6_rst_count", key_count, 0);
    chk("t6_rst_code", key_code, 0);
    chk("t6_rst_ovf", overflow, 0);
    model_reset();
    tick();
    KeyRead = 1'b0;
    RESET   = 1'b0;
    hold(1'b0, 4'd3, 30);
    chk("t6_no_event", obs.size(), 0);

    // Long hold
    start_test();
`ifdef AUTOREPEAT_EN
    exp_hold = 4;
`else
    exp_hold = 1;
`endif
    hold(1'b1, 4'd9, 1500);
    hold(1'b0, 4'd9, 20);
    chk("t7_events", obs.size(), exp_hold);
    chk("t7_code", obs_at(obs.size() - 1), 9);
    chk("t7_latency", fv, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
